adder_carry_pipe: RTL and testbench

//  Parametrised, pipelined ripple-carry adder for the datapath arithmetic slice.

---
 rtl/adder_carry_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_adder_carry_pipe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_carry_pipe.sv
// ---------------------------------------------------------------------------
// adder_carry_pipe
//
// Purpose
//   Pipelined ripple-carry adder. A WIDTH-bit add is split into STAGES equal
//   chunks of CW = WIDTH/STAGES bits. Stage k adds chunk k using the carry
//   registered by stage k-1. The result emerges exactly STAGES cycles after
//   it is accepted, with a throughput of one result per cycle.
//
//   Operand bits that are not yet added travel forward in skew registers.
//   Completed low-order sum bits also travel forward, so the last stage holds
//   the full sum.
//
//   The whole pipeline advances as one unit (adv). When the output is held
//   by the downstream side, every stage freezes, so nothing is dropped or
//   duplicated. Bubbles travel through the pipeline as invalid stages.
//
// Parameters
//   WIDTH   operand/sum width; must be a multiple of STAGES
//   STAGES  pipeline depth (>= 1), one carry chunk per stage
//
// Optional feature
//   ADDER_CARRY_PIPE_SUB_EN  adds the in_sub port. When in_sub=1 stage 0 uses
//                            ~in_b and an inverted carry-in, so sub=1, cin=0
//                            computes A-B (out_cout=1 means no borrow).
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      operands accepted this cycle (= adv)
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry-in
//   in_sub     in   1      subtract select (ADDER_CARRY_PIPE_SUB_EN only)
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_sum    out  WIDTH  sum (registered)
//   out_cout   out  1      carry out of bit WIDTH-1 (registered)
//   out_ovf    out  1      two's complement overflow (registered)
// ---------------------------------------------------------------------------
module adder_carry_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADDER_CARRY_PIPE_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int CW = WIDTH / STAGES;

    // Ripple-carry add of one chunk. Returns {carry_out, sum}.
    function automatic logic [CW:0] chunk_add(
        input logic [CW-1:0] a,
        input logic [CW-1:0] b,
        input logic          c_in
    );
        logic          c;
        logic [CW-1:0] s;
        c = c_in;
        s = '0;
        for (int i = 0; i < CW; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
        end
        return {c, s};
    endfunction

    // -----------------------------------------------------------------------
    // Front end: effective B operand and carry into stage 0
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic             carry0;

`ifdef ADDER_CARRY_PIPE_SUB_EN
    // Subtraction is A + ~B + 1. Inverting cin keeps its meaning as a
    // borrow-in chain when sub=1.
    assign b_eff  = in_sub ? ~in_b : in_b;
    assign carry0 = in_cin ^ in_sub;
`else
    assign b_eff  = in_b;
    assign carry0 = in_cin;
`endif

    // One global advance. It depends only on the output register and
    // out_ready, so in_ready has no combinational path from in_valid.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // -----------------------------------------------------------------------
    // Pipeline stages
    // Stage gi receives:
    //   - the operand bits from chunk gi upward (HI_IN bits), and
    //   - the LO completed sum bits below chunk gi.
    // Stage gi registers:
    //   - LO+CW sum bits, its carry-out, its valid bit, and
    //   - the operand bits above its chunk, which go to the next stage.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : gen_stage
            localparam int LO    = gi * CW;
            localparam int HI_IN = WIDTH - LO;

            logic [HI_IN-1:0]   a_in;
            logic [HI_IN-1:0]   b_in;
            logic               c_in;
            logic               v_in;
            logic [CW:0]        res;
            logic [LO+CW-1:0]   sum_d;

            logic [LO+CW-1:0]   sum_q;
            logic               carry_q;
            logic               valid_q;

            assign res = chunk_add(a_in[CW-1:0], b_in[CW-1:0], c_in);

            if (gi == 0) begin : g_src
                assign a_in  = in_a;
                assign b_in  = b_eff;
                assign c_in  = carry0;
                assign v_in  = in_valid;
                assign sum_d = res[CW-1:0];
            end else begin : g_src
                assign a_in  = gen_stage[gi-1].g_skew.a_hi_q;
                assign b_in  = gen_stage[gi-1].g_skew.b_hi_q;
                assign c_in  = gen_stage[gi-1].carry_q;
                assign v_in  = gen_stage[gi-1].valid_q;
                assign sum_d = {res[CW-1:0], gen_stage[gi-1].sum_q};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    carry_q <= 1'b0;
                    sum_q   <= '0;
                end else if (adv) begin
                    valid_q <= v_in;
                    carry_q <= res[CW];
                    sum_q   <= sum_d;
                end
            end

            // Skew registers: operand chunks still waiting for their stage.
            if (gi < STAGES - 1) begin : g_skew
                logic [HI_IN-CW-1:0] a_hi_q;
                logic [HI_IN-CW-1:0] b_hi_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_hi_q <= '0;
                        b_hi_q <= '0;
                    end else if (adv) begin
                        a_hi_q <= a_in[HI_IN-1:CW];
                        b_hi_q <= b_in[HI_IN-1:CW];
                    end
                end
            end

            // Final stage also registers signed overflow. The carry into the
            // MSB is recovered as sum ^ a ^ b at that bit, so it is not
            // carried separately. For CW=1 it is the incoming chunk carry,
            // which gives cout ^ cin when WIDTH=1.
            if (gi == STAGES - 1) begin : g_last
                logic ovf_d;
                logic ovf_q;

                assign ovf_d = res[CW] ^ (res[CW-1] ^ a_in[CW-1] ^ b_in[CW-1]);

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_q <= 1'b0;
                    end else if (adv) begin
                        ovf_q <= ovf_d;
                    end
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs come straight from the last stage registers
    // -----------------------------------------------------------------------
    assign out_valid = gen_stage[STAGES-1].valid_q;
    assign out_sum   = gen_stage[STAGES-1].sum_q;
    assign out_cout  = gen_stage[STAGES-1].carry_q;
    assign out_ovf   = gen_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_adder_carry_pipe.sv
// ---------------------------------------------------------------------------
// tb_adder_carry_pipe
//   Directed bench for adder_carry_pipe. It drives three configurations side
//   by side:
//     c0: WIDTH=32, STAGES=4
//     c1: WIDTH=32, STAGES=1
//     c2: WIDTH=8,  STAGES=8
//   Each configuration checks:
//     - reset values,
//     - the carry-chain and overflow vectors (hand-computed results),
//     - latency,
//     - a 16-op stream under a 1,1,0,0,1,0 out_ready pattern, and
//     - reset while operations are in flight.
//   Results are packed as {ovf, cout, sum} in a 64-bit word.
// ---------------------------------------------------------------------------
module tb_adder_carry_pipe;

    logic clk;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [2:0] done = 3'b000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} of a w-bit add or subtract.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub, input int w);
        logic [32:0] m;
        logic [32:0] full;
        logic [31:0] am;
        logic [31:0] bm;
        logic [31:0] s;
        logic        co;
        logic        ov;
        m    = (33'd1 << w) - 33'd1;
        am   = a & m[31:0];
        bm   = (sub ? ~b : b) & m[31:0];
        full = {1'b0, am} + {1'b0, bm} + {32'd0, cin ^ sub};
        s    = full[31:0] & m[31:0];
        co   = full[w];
        ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
        return {30'd0, ov, co, s};
    endfunction

    // Hand-computed directed vectors for 32-bit and 8-bit widths.
    task automatic hand(input int w, input int idx, output logic [31:0] a,
                        output logic [31:0] b, output logic cin, output logic [63:0] ex);
        cin = 1'b0;
        b   = 32'd1;
        case (idx)
            0: begin a = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF; ex = 64'h1_0000_0000; end
            1: begin a = (w == 32) ? 32'h7FFF_FFFF : 32'h0000_007F;
                     ex = (w == 32) ? 64'h2_8000_0000 : 64'h2_0000_0080; end
            2: begin a = (w == 32) ? 32'h8000_0000 : 32'h0000_0080; b = a; ex = 64'h3_0000_0000; end
            default: begin
                a   = (w == 32) ? 32'h1234_5678 : 32'h0000_0056;
                b   = (w == 32) ? 32'h1111_1111 : 32'h0000_0011;
                cin = 1'b1;
                ex  = (w == 32) ? 64'h0_2345_678A : 64'h0_0000_0068;
            end
        endcase
    endtask

    localparam logic [31:0] SA [16] = '{
        32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
        32'h1234_5678, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'hAAAA_AAAA,
        32'h5555_5555, 32'hCAFE_F00D, 32'h0000_00FF, 32'h00FF_FF00,
        32'h8765_4321, 32'hFFFF_0000, 32'h3C3C_3C3C, 32'h9999_9999};
    localparam logic [31:0] SB [16] = '{
        32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0001,
        32'h8765_4321, 32'h2152_4111, 32'hF0F0_F0F0, 32'h5555_5556,
        32'h5555_5555, 32'h3501_0FF3, 32'h0000_0001, 32'h0000_0100,
        32'h789A_BCDF, 32'h0001_0000, 32'hC3C3_C3C4, 32'h6666_6666};

    // out_ready pattern 1,1,0,0,1,0 (bit 0 is applied first)
    localparam logic [5:0] PAT = 6'b010011;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cfg
            localparam int W = (gi == 2) ? 8 : 32;
            localparam int S = (gi == 0) ? 4 : ((gi == 1) ? 1 : 8);

            logic         rst_n_l;
            logic         in_valid_l;
            logic         in_ready_l;
            logic [W-1:0] in_a_l;
            logic [W-1:0] in_b_l;
            logic         in_cin_l;
`ifdef ADDER_CARRY_PIPE_SUB_EN
            logic         in_sub_l;
`endif
            logic         out_valid_l;
            logic         out_ready_l;
            logic [W-1:0] out_sum_l;
            logic         out_cout_l;
            logic         out_ovf_l;

            logic [63:0]  exp_q [$];
            int           pc;

            adder_carry_pipe #(.WIDTH(W), .STAGES(S)) dut (
                .clk      (clk),
                .rst_n    (rst_n_l),
                .in_valid (in_valid_l),
                .in_ready (in_ready_l),
                .in_a     (in_a_l),
                .in_b     (in_b_l),
                .in_cin   (in_cin_l),
`ifdef ADDER_CARRY_PIPE_SUB_EN
                .in_sub   (in_sub_l),
`endif
                .out_valid(out_valid_l),
                .out_ready(out_ready_l),
                .out_sum  (out_sum_l),
                .out_cout (out_cout_l),
                .out_ovf  (out_ovf_l)
            );

            function automatic logic [63:0] observed();
                return {30'd0, out_ovf_l, out_cout_l, 32'(out_sum_l)};
            endfunction

            // One cycle:
            //   - drive the inputs at the negedge;
            //   - check the held or outgoing result against the queue head;
            //   - record the accepted operation.
            task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic sub, input logic rdy,
                               input logic [63:0] ex, output logic acc, output logic saw);
                @(negedge clk);
                in_valid_l  = v;
                in_a_l      = a[W-1:0];
                in_b_l      = b[W-1:0];
                in_cin_l    = cin;
`ifdef ADDER_CARRY_PIPE_SUB_EN
                in_sub_l    = sub;
`endif
                out_ready_l = rdy;
                #1;
                check($sformatf("c%0d/in_ready", gi), {63'd0, in_ready_l}, {63'd0, ~out_valid_l | rdy});
                saw = out_valid_l;
                if (out_valid_l) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("c%0d/spurious_out", gi), 64'd1, 64'd0);
                    end else begin
                        check($sformatf("c%0d/result", gi), observed(), exp_q[0]);
                        if (rdy) begin
                            $display("c%0d result %h", gi, observed());
                            void'(exp_q.pop_front());
                        end
                    end
                end
                acc = v & in_ready_l;
                if (acc) exp_q.push_back(ex);
            endtask

            task automatic lat_check(input string tag);
                int   lat;
                logic acc;
                logic saw;
                lat = 0;
                saw = 1'b0;
                while (!saw && lat < 20) begin
                    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 64'd0, acc, saw);
                    lat++;
                end
                check($sformatf("c%0d/%s", gi, tag), 64'(lat), 64'(S));
            endtask

            task automatic drain(input logic use_pat);
                logic acc;
                logic saw;
                for (int t = 0; t < 200 && exp_q.size() > 0; t++) begin
                    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, use_pat ? PAT[pc % 6] : 1'b1, 64'd0, acc, saw);
                    pc++;
                end
                check($sformatf("c%0d/drain_left", gi), 64'(exp_q.size()), 64'd0);
            endtask

            initial begin
                logic [31:0] a;
                logic [31:0] b;
                logic        cin;
                logic [63:0] ex;
                logic        acc;
                logic        saw;
                pc = 0;

                // ---- reset with in_valid asserted and out_ready low ----
                rst_n_l = 1'b1;
                hand(W, 0, a, b, cin, ex);
                in_valid_l  = 1'b1;
                in_a_l      = a[W-1:0];
                in_b_l      = b[W-1:0];
                in_cin_l    = cin;
`ifdef ADDER_CARRY_PIPE_SUB_EN
                in_sub_l    = 1'b0;
`endif
                out_ready_l = 1'b0;
                #1 rst_n_l = 1'b0;
                repeat (3) @(negedge clk);
                #1;
                check($sformatf("c%0d/rst_valid", gi), {63'd0, out_valid_l}, 64'd0);
                check($sformatf("c%0d/rst_sum", gi), 64'(out_sum_l), 64'd0);
                check($sformatf("c%0d/rst_cout", gi), {63'd0, out_cout_l}, 64'd0);
                check($sformatf("c%0d/rst_ovf", gi), {63'd0, out_ovf_l}, 64'd0);
                check($sformatf("c%0d/rst_ready", gi), {63'd0, in_ready_l}, 64'd1);

                // Release while vector 0 is presented; the first edge accepts it.
                out_ready_l = 1'b1;
                rst_n_l     = 1'b1;
                exp_q.push_back(ex);
                lat_check("latency_first");

                // ---- carry chain / overflow vectors, back to back ----
                for (int k = 1; k < 4; k++) begin
                    hand(W, k, a, b, cin, ex);
                    cyc(1'b1, a, b, cin, 1'b0, 1'b1, ex, acc, saw);
                    check($sformatf("c%0d/accept_dir%0d", gi, k), {63'd0, acc}, 64'd1);
                end
                drain(1'b0);

                // ---- backpressure stream ----
                for (int i = 0; i < 16; i++) begin
                    acc = 1'b0;
                    for (int t = 0; t < 50 && !acc; t++) begin
                        cyc(1'b1, SA[i], SB[i], i[0], 1'b0, PAT[pc % 6],
                            model(SA[i], SB[i], i[0], 1'b0, W), acc, saw);
                        pc++;
                    end
                    if (!acc) check($sformatf("c%0d/stream_accept_timeout", gi), 64'd0, 64'd1);
                end
                drain(1'b1);

                // ---- reset with three operations in flight ----
                for (int i = 0; i < 3; i++) begin
                    cyc(1'b1, SA[i+4], SB[i+4], 1'b0, 1'b0, 1'b1,
                        model(SA[i+4], SB[i+4], 1'b0, 1'b0, W), acc, saw);
                end
                @(negedge clk);
                in_valid_l = 1'b0;
                rst_n_l    = 1'b0;
                #1;
                check($sformatf("c%0d/midrst_valid", gi), {63'd0, out_valid_l}, 64'd0);
                exp_q.delete();
                @(negedge clk);
                rst_n_l = 1'b1;
                repeat (S + 3) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 64'd0, acc, saw);
                cyc(1'b1, SA[9], SB[9], 1'b1, 1'b0, 1'b1, model(SA[9], SB[9], 1'b1, 1'b0, W), acc, saw);
                lat_check("latency_after_rst");
                drain(1'b0);

`ifdef ADDER_CARRY_PIPE_SUB_EN
                // ---- subtraction ----
                cyc(1'b1, 32'd5, 32'd7, 1'b0, 1'b1, 1'b1,
                    (W == 32) ? 64'h0_FFFF_FFFE : 64'h0_0000_00FE, acc, saw);
                cyc(1'b1, 32'd5, 32'd3, 1'b0, 1'b1, 1'b1, 64'h1_0000_0002, acc, saw);
                drain(1'b0);
`endif
                done[gi] = 1'b1;
            end
        end
    endgenerate

    initial begin
        for (int t = 0; t < 20000; t++) begin
            if (&done) break;
            @(posedge clk);
        end
        check("all_configs_done", {61'd0, done}, 64'd7);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
